// File: rtl/minirisc_pkg.sv
// Shared encodings for the mini-RISC control unit: opcodes, ALU codes, mux selects,
// FSM states, plus the opcode classifier used in DECODE.
package minirisc_pkg;

  localparam logic [5:0] OP_RALU  = 6'd0;
  localparam logic [5:0] OP_ADDI  = 6'd1;
  localparam logic [5:0] OP_LD    = 6'd2;
  localparam logic [5:0] OP_ST    = 6'd3;
  localparam logic [5:0] OP_BR    = 6'd4;
  localparam logic [5:0] OP_BZ    = 6'd5;
  localparam logic [5:0] OP_BNZ   = 6'd6;
  localparam logic [5:0] OP_BLTZ  = 6'd7;
  localparam logic [5:0] OP_CALL  = 6'd8;
  localparam logic [5:0] OP_HALT  = 6'd9;
  localparam logic [5:0] OP_COMPI = 6'd10;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_COMP  = 4'd1;
  localparam logic [3:0] ALU_AND   = 4'd2;
  localparam logic [3:0] ALU_XOR   = 4'd3;
  localparam logic [3:0] ALU_SHLL  = 4'd4;
  localparam logic [3:0] ALU_SHRL  = 4'd5;
  localparam logic [3:0] ALU_SHLLV = 4'd6;
  localparam logic [3:0] ALU_SHRLV = 4'd7;
  localparam logic [3:0] ALU_SHRA  = 4'd8;
  localparam logic [3:0] ALU_SHRAV = 4'd9;

  localparam logic [1:0] PC_SEL_SEQ   = 2'd0;
  localparam logic [1:0] PC_SEL_LABEL = 2'd1;
  localparam logic [1:0] PC_SEL_REL   = 2'd2;
  localparam logic [1:0] PC_SEL_RS    = 2'd3;

  localparam logic [1:0] WSEL_ALU  = 2'd0;
  localparam logic [1:0] WSEL_MEM  = 2'd1;
  localparam logic [1:0] WSEL_LINK = 2'd2;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    CL_ALU,
    CL_LD,
    CL_ST,
    CL_BR,
    CL_BZ,
    CL_BNZ,
    CL_BLTZ,
    CL_CALL
  } iclass_t;

  typedef struct packed {
    logic       legal;
    logic       halt;
    iclass_t    cls;
    logic [3:0] alu;
    logic       src_imm;
  } dec_t;

  function automatic dec_t decode_op(input logic [5:0] opcode, input logic [5:0] func);
    dec_t d;
    d.legal   = 1'b1;
    d.halt    = 1'b0;
    d.cls     = CL_ALU;
    d.alu     = ALU_ADD;
    d.src_imm = 1'b0;
    case (opcode)
      OP_RALU: begin
        d.alu   = func[3:0];
        d.legal = (func[5:4] == 2'b00);
      end
      OP_ADDI:  d.src_imm = 1'b1;
      OP_COMPI: begin
        d.src_imm = 1'b1;
        d.alu     = ALU_COMP;
      end
      OP_LD: begin
        d.cls     = CL_LD;
        d.src_imm = 1'b1;
      end
      OP_ST: begin
        d.cls     = CL_ST;
        d.src_imm = 1'b1;
      end
      OP_BR:   d.cls  = CL_BR;
      OP_BZ:   d.cls  = CL_BZ;
      OP_BNZ:  d.cls  = CL_BNZ;
      OP_BLTZ: d.cls  = CL_BLTZ;
      OP_CALL: d.cls  = CL_CALL;
      OP_HALT: d.halt = 1'b1;
      default: d.legal = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/minirisc_mem_timer.sv
// Counts consecutive ack-less wait cycles; expired flags the MEM_TIMEOUT-th such cycle.
// No latency beyond one register; an ack in the expiring cycle drops en and so wins.
module minirisc_mem_timer #(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] cnt;

  assign expired = en && (cnt == TO_W'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt <= '0;
    end else if (en && !expired) begin
      cnt <= cnt + TO_W'(1);
    end
  end

endmodule

// File: rtl/minirisc_ctrl_fsm.sv
// Multi-cycle control sequencer: FETCH/DECODE/EXEC/MEM/WB/HALT, one instruction at a time.
// Waits on imem_ack/dmem_ack with a shared timeout; a timeout halts with sticky bus_error.
module minirisc_ctrl_fsm
  import minirisc_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_W        = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] func,
  input  logic       rs_zero,
  input  logic       rs_neg,
  input  logic       imem_ack,
  input  logic       dmem_ack,
  output logic       imem_req,
  output logic       ir_load,
  output logic       pc_load,
  output logic [1:0] pc_sel,
  output logic       rf_we,
  output logic [1:0] rf_wsel,
  output logic       alu_src_imm,
  output logic [3:0] alu_ctrl,
  output logic       dmem_req,
  output logic       dmem_we,
  output logic       halted,
  output logic       illegal_op,
  output logic       bus_error
);

  state_t     state;
  iclass_t    cls_q;
  logic [3:0] alu_q;
  logic       src_q;
  logic       bus_err_q;
  dec_t       dec;
  logic       wait_miss;
  logic       to_expired;

  assign dec = decode_op(opcode, func);

  // Only ack-less FETCH/MEM cycles advance the timer; any other cycle clears it,
  // so every entry into a waiting state starts from zero.
  assign wait_miss = ((state == S_FETCH) && !imem_ack) || ((state == S_MEM) && !dmem_ack);

  minirisc_mem_timer #(
    .MEM_TIMEOUT(MEM_TIMEOUT),
    .TO_W       (TO_W)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (!wait_miss),
    .en     (wait_miss),
    .expired(to_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_FETCH;
      cls_q     <= CL_ALU;
      alu_q     <= '0;
      src_q     <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: begin
          if (imem_ack) begin
            state <= S_DECODE;
          end else if (to_expired) begin
            state     <= S_HALT;
            bus_err_q <= 1'b1;
          end
        end
        S_DECODE: begin
          if (dec.halt) begin
            state <= S_HALT;
          end else if (dec.legal) begin
            state <= S_EXEC;
            cls_q <= dec.cls;
            alu_q <= dec.alu;
            src_q <= dec.src_imm;
          end else begin
            state <= S_FETCH;
          end
        end
        S_EXEC: begin
          case (cls_q)
            CL_ALU:       state <= S_WB;
            CL_LD, CL_ST: state <= S_MEM;
            default:      state <= S_FETCH;
          endcase
        end
        S_MEM: begin
          if (dmem_ack) begin
            state <= (cls_q == CL_ST) ? S_FETCH : S_WB;
          end else if (to_expired) begin
            state     <= S_HALT;
            bus_err_q <= 1'b1;
          end
        end
        S_WB:    state <= S_FETCH;
        S_HALT:  state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    imem_req    = 1'b0;
    ir_load     = 1'b0;
    pc_load     = 1'b0;
    pc_sel      = PC_SEL_SEQ;
    rf_we       = 1'b0;
    rf_wsel     = WSEL_ALU;
    alu_src_imm = 1'b0;
    alu_ctrl    = ALU_ADD;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    halted      = 1'b0;
    illegal_op  = 1'b0;
    bus_error   = bus_err_q;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        ir_load  = imem_ack;
      end
      S_DECODE: begin
        // Unknown opcodes retire as a NOP: step the PC and refetch.
        if (!dec.legal) begin
          illegal_op = 1'b1;
          pc_load    = 1'b1;
        end
      end
      S_EXEC: begin
        alu_ctrl    = alu_q;
        alu_src_imm = src_q;
        case (cls_q)
          CL_BR: begin
            pc_load = 1'b1;
            pc_sel  = PC_SEL_LABEL;
          end
          CL_BZ: begin
            pc_load = 1'b1;
            pc_sel  = rs_zero ? PC_SEL_REL : PC_SEL_SEQ;
          end
          CL_BNZ: begin
            pc_load = 1'b1;
            pc_sel  = rs_zero ? PC_SEL_SEQ : PC_SEL_REL;
          end
          CL_BLTZ: begin
            pc_load = 1'b1;
            pc_sel  = rs_neg ? PC_SEL_REL : PC_SEL_SEQ;
          end
          CL_CALL: begin
            pc_load = 1'b1;
            pc_sel  = PC_SEL_LABEL;
            rf_we   = 1'b1;
            rf_wsel = WSEL_LINK;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        alu_ctrl    = alu_q;
        alu_src_imm = src_q;
        dmem_req    = 1'b1;
        dmem_we     = (cls_q == CL_ST);
        if (dmem_ack && (cls_q == CL_ST)) begin
          pc_load = 1'b1;
        end
      end
      S_WB: begin
        alu_ctrl    = alu_q;
        alu_src_imm = src_q;
        rf_we       = 1'b1;
        rf_wsel     = (cls_q == CL_LD) ? WSEL_MEM : WSEL_ALU;
        pc_load     = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_minirisc_ctrl_fsm.sv
// Instruction-level trace model: each instruction expands into its expected per-cycle
// output vectors, which are replayed against the DUT and compared every cycle.
module tb_minirisc_ctrl_fsm;

  localparam int TO = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] func = '0;
  logic       rs_zero = 1'b0;
  logic       rs_neg = 1'b0;
  logic       imem_ack = 1'b0;
  logic       dmem_ack = 1'b0;
  logic       imem_req, ir_load, pc_load, rf_we, alu_src_imm;
  logic       dmem_req, dmem_we, halted, illegal_op, bus_error;
  logic [1:0] pc_sel, rf_wsel;
  logic [3:0] alu_ctrl;

  minirisc_ctrl_fsm #(.MEM_TIMEOUT(TO), .TO_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func),
    .rs_zero(rs_zero), .rs_neg(rs_neg), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .imem_req(imem_req), .ir_load(ir_load), .pc_load(pc_load), .pc_sel(pc_sel),
    .rf_we(rf_we), .rf_wsel(rf_wsel), .alu_src_imm(alu_src_imm), .alu_ctrl(alu_ctrl),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .halted(halted),
    .illegal_op(illegal_op), .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       imem_req;
    logic       ir_load;
    logic       pc_load;
    logic [1:0] pc_sel;
    logic       rf_we;
    logic [1:0] rf_wsel;
    logic       alu_src_imm;
    logic [3:0] alu_ctrl;
    logic       dmem_req;
    logic       dmem_we;
    logic       halted;
    logic       illegal_op;
    logic       bus_error;
  } outs_t;

  typedef struct {
    logic       r, ia, da, rz, rn;
    logic [5:0] op, fn;
    outs_t      e;
    bit         chk;
  } step_t;

  step_t      plan[$];
  outs_t      exp_q[$];
  bit         chk_q[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic [5:0] g_op, g_fn;
  logic       g_rz, g_rn;
  bit         m_bus = 1'b0;
  outs_t      got;

  assign got = {imem_req, ir_load, pc_load, pc_sel, rf_we, rf_wsel, alu_src_imm,
                alu_ctrl, dmem_req, dmem_we, halted, illegal_op, bus_error};

  function automatic logic rb();
    return ($urandom % 2) == 1;
  endfunction

  function automatic void push(logic r, logic ia, logic da, outs_t e, bit chk);
    step_t s;
    s.r = r; s.ia = ia; s.da = da; s.rz = g_rz; s.rn = g_rn;
    s.op = g_op; s.fn = g_fn; s.e = e; s.chk = chk;
    plan.push_back(s);
  endfunction

  function automatic void add_halt(int n);
    outs_t e;
    for (int i = 0; i < n; i++) begin
      e = '0; e.halted = 1'b1; e.bus_error = m_bus;
      push(1'b0, rb(), rb(), e, 1'b1);
    end
  endfunction

  function automatic void add_rst();
    push(1'b1, 1'b0, 1'b0, '0, 1'b0);
    push(1'b1, 1'b0, 1'b0, '0, 1'b0);
    m_bus = 1'b0;
  endfunction

  // Expand one instruction into cycle vectors; returns 1 if the machine ends up halted.
  function automatic bit gen_instr(int fwait, int mwait);
    outs_t e, ex;
    bit legal = 1'b1, is_alu = 1'b0, is_ld = 1'b0, is_st = 1'b0;
    bit is_halt = 1'b0, is_call = 1'b0;
    int br = -1;
    logic [3:0] a = 4'd0;
    logic s = 1'b0;
    for (int i = 0; i < fwait && i < TO; i++) begin
      e = '0; e.imem_req = 1'b1;
      push(1'b0, 1'b0, rb(), e, 1'b1);
    end
    if (fwait >= TO) begin
      m_bus = 1'b1;
      return 1'b1;
    end
    e = '0; e.imem_req = 1'b1; e.ir_load = 1'b1;
    push(1'b0, 1'b1, rb(), e, 1'b1);
    case (g_op)
      6'd0:  begin is_alu = 1'b1; a = g_fn[3:0]; legal = (g_fn[5:4] == 2'd0); end
      6'd1:  begin is_alu = 1'b1; s = 1'b1; end
      6'd10: begin is_alu = 1'b1; s = 1'b1; a = 4'd1; end
      6'd2:  begin is_ld = 1'b1; s = 1'b1; end
      6'd3:  begin is_st = 1'b1; s = 1'b1; end
      6'd4:  br = 1;
      6'd5:  br = g_rz ? 2 : 0;
      6'd6:  br = g_rz ? 0 : 2;
      6'd7:  br = g_rn ? 2 : 0;
      6'd8:  begin br = 1; is_call = 1'b1; end
      6'd9:  is_halt = 1'b1;
      default: legal = 1'b0;
    endcase
    e = '0;
    if (!legal) begin e.illegal_op = 1'b1; e.pc_load = 1'b1; end
    push(1'b0, rb(), rb(), e, 1'b1);
    if (!legal) return 1'b0;
    if (is_halt) return 1'b1;
    ex = '0; ex.alu_ctrl = a; ex.alu_src_imm = s;
    e = ex;
    if (br >= 0) begin
      e.pc_load = 1'b1; e.pc_sel = 2'(br);
      if (is_call) begin e.rf_we = 1'b1; e.rf_wsel = 2'd2; end
    end
    push(1'b0, rb(), rb(), e, 1'b1);
    if (is_ld || is_st) begin
      for (int i = 0; i < mwait && i < TO; i++) begin
        e = ex; e.dmem_req = 1'b1; e.dmem_we = is_st;
        push(1'b0, rb(), 1'b0, e, 1'b1);
      end
      if (mwait >= TO) begin
        m_bus = 1'b1;
        return 1'b1;
      end
      e = ex; e.dmem_req = 1'b1; e.dmem_we = is_st;
      if (is_st) e.pc_load = 1'b1;
      push(1'b0, rb(), 1'b1, e, 1'b1);
      if (is_st) return 1'b0;
    end
    if (is_alu || is_ld) begin
      e = ex; e.rf_we = 1'b1; e.rf_wsel = is_ld ? 2'd1 : 2'd0; e.pc_load = 1'b1;
      push(1'b0, rb(), rb(), e, 1'b1);
    end
    return 1'b0;
  endfunction

  function automatic void pin(string name, int actual, int want);
    vectors++;
    if (actual != want) begin
      miscompares++;
      $display("FAIL pin %s: got %0d want %0d", name, actual, want);
    end
  endfunction

  function automatic void set_instr(logic [5:0] op, logic [5:0] fn, logic rz, logic rn);
    g_op = op; g_fn = fn; g_rz = rz; g_rn = rn;
  endfunction

  function automatic int count_plan(int field);
    int n = 0;
    foreach (plan[i]) begin
      case (field)
        0: n += int'(plan[i].e.dmem_req);
        1: n += int'(plan[i].e.dmem_we);
        2: n += int'(plan[i].e.rf_we);
        default: n += int'(plan[i].e.imem_req);
      endcase
    end
    return n;
  endfunction

  task automatic run_plan();
    step_t s;
    while (plan.size() > 0) begin
      s = plan.pop_front();
      @(posedge clk);
      #1;
      rst = s.r; imem_ack = s.ia; dmem_ack = s.da;
      opcode = s.op; func = s.fn; rs_zero = s.rz; rs_neg = s.rn;
      exp_q.push_back(s.e);
      chk_q.push_back(s.chk);
    end
  endtask

  task automatic do_instr(logic [5:0] op, logic [5:0] fn, logic rz, logic rn, int fw, int mw);
    set_instr(op, fn, rz, rn);
    if (gen_instr(fw, mw)) begin
      add_halt(3 + int'($urandom % 4));
      add_rst();
    end
    run_plan();
  endtask

  always @(negedge clk) begin
    outs_t w;
    bit c;
    if (exp_q.size() > 0) begin
      w = exp_q.pop_front();
      c = chk_q.pop_front();
      if (c) begin
        vectors++;
        if (got !== w) begin
          miscompares++;
          $display("FAIL outputs @%0t: got %b want %b", $time, got, w);
        end
      end
    end
  end

  initial begin
    outs_t e;
    int r, fw, mw;
    logic [5:0] op, fn;

    // R-type add after reset: ir_load cycle 1, rf_we cycle 4, refetch cycle 5.
    set_instr(6'd0, 6'd0, 1'b0, 1'b0);
    add_rst();
    void'(gen_instr(0, 0));
    pin("add_len", plan.size(), 6);
    pin("add_irload_c1", int'(plan[2].e.ir_load), 1);
    pin("add_rfwe_c4", int'(plan[5].e.rf_we), 1);
    pin("add_pcload_c4", int'(plan[5].e.pc_load), 1);
    run_plan();

    // LD with dmem_ack three cycles late.
    set_instr(6'd2, 6'd0, 1'b0, 1'b0);
    void'(gen_instr(0, 3));
    pin("ld_refetch_c5", int'(plan[0].e.imem_req), 1);
    pin("ld_dmem_req_cycles", count_plan(0), 4);
    pin("ld_dmem_we_cycles", count_plan(1), 0);
    pin("ld_rf_we_cycles", count_plan(2), 1);
    pin("ld_wsel", int'(plan[plan.size()-1].e.rf_wsel), 1);
    run_plan();

    set_instr(6'd5, 6'd0, 1'b1, 1'b0);
    void'(gen_instr(0, 0));
    pin("bz_taken_sel", int'(plan[2].e.pc_sel), 2);
    pin("bz_no_rf_we", count_plan(2), 0);
    run_plan();
    set_instr(6'd5, 6'd0, 1'b0, 1'b0);
    void'(gen_instr(1, 0));
    pin("bz_not_taken_sel", int'(plan[3].e.pc_sel), 0);
    run_plan();
    set_instr(6'd7, 6'd0, 1'b0, 1'b1);
    void'(gen_instr(0, 0));
    pin("bltz_taken_sel", int'(plan[2].e.pc_sel), 2);
    run_plan();

    set_instr(6'd8, 6'd0, 1'b0, 1'b0);
    void'(gen_instr(0, 0));
    pin("call_exec", int'({plan[2].e.rf_we, plan[2].e.rf_wsel, plan[2].e.pc_sel, plan[2].e.pc_load}), 'b1_10_01_1);
    run_plan();

    // Fetch timeout boundary: ack on the 16th cycle wins, none at all halts.
    do_instr(6'd1, 6'd0, 1'b0, 1'b0, TO - 1, 0);
    set_instr(6'd1, 6'd0, 1'b0, 1'b0);
    void'(gen_instr(TO, 0));
    pin("fetch_timeout_req_cycles", count_plan(3), TO);
    add_halt(5);
    add_rst();
    run_plan();

    do_instr(6'd3, 6'd0, 1'b0, 1'b0, 0, TO - 1);
    do_instr(6'd3, 6'd0, 1'b0, 1'b0, 0, TO);
    do_instr(6'd2, 6'd0, 1'b0, 1'b0, 2, TO);

    do_instr(6'd63, 6'd0, 1'b0, 1'b0, 0, 0);
    do_instr(6'd0, 6'd3, 1'b0, 1'b0, 0, 0);
    do_instr(6'd0, 6'h21, 1'b0, 1'b0, 0, 0);
    do_instr(6'd9, 6'd0, 1'b0, 1'b0, 0, 0);

    // Reset in the middle of a load: request drops, no writeback.
    set_instr(6'd2, 6'd0, 1'b0, 1'b0);
    e = '0; e.imem_req = 1'b1; e.ir_load = 1'b1;
    push(1'b0, 1'b1, 1'b0, e, 1'b1);
    push(1'b0, 1'b0, 1'b0, '0, 1'b1);
    e = '0; e.alu_src_imm = 1'b1;
    push(1'b0, 1'b0, 1'b0, e, 1'b1);
    e.dmem_req = 1'b1;
    push(1'b0, 1'b0, 1'b0, e, 1'b1);
    push(1'b1, 1'b0, 1'b0, e, 1'b1);
    run_plan();
    do_instr(6'd1, 6'd0, 1'b0, 1'b0, 0, 0);

    for (int n = 0; n < 250; n++) begin
      r = int'($urandom % 20);
      fn = 6'($urandom);
      if (($urandom % 8) != 0) fn[5:4] = 2'd0;
      case (r)
        0, 1, 2, 3, 17, 18: op = 6'd0;
        4:  op = 6'd1;
        5:  op = 6'd10;
        6, 7: op = 6'd2;
        8, 9: op = 6'd3;
        10: op = 6'd4;
        11: op = 6'd5;
        12: op = 6'd6;
        13: op = 6'd7;
        14: op = 6'd8;
        15: op = (($urandom % 4) == 0) ? 6'd9 : 6'd1;
        default: op = 6'(11 + ($urandom % 53));
      endcase
      r = int'($urandom % 32);
      fw = (r < 20) ? 0 : (r < 28) ? int'($urandom % 4) : (r == 28) ? TO - 1 : (r == 29) ? TO : int'($urandom % 8);
      r = int'($urandom % 32);
      mw = (r < 20) ? 0 : (r < 28) ? int'($urandom % 4) : (r == 28) ? TO - 1 : (r == 29) ? TO : int'($urandom % 8);
      do_instr(op, fn, rb(), rb(), fw, mw);
    end

    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/minirisc_ctrl_fsm.md
Name: minirisc_ctrl_fsm

Overview:
Multi-cycle control unit for the KGP mini-RISC datapath. It consumes the opcode/func fields produced by the instruction decoder and sequences fetch, decode, execute, memory and writeback. It drives register-file, ALU, PC and data-memory controls, and handshakes with instruction and data memory. It sits between the decoder and the datapath muxes in the CPU top level.

Parameters:
MEM_TIMEOUT, 16, max cycles to wait for imem_ack/dmem_ack before declaring bus_error (≥2)
TO_W, 5, timeout counter width (must hold MEM_TIMEOUT)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous reset, active-high
opcode  in  6  decoder opcode field (instr[31:26])
func  in  6  decoder func field (instr[5:0]); valid only for OP_RALU
rs_zero  in  1  regfile read of rs == 0
rs_neg  in  1  regfile read of rs < 0 (bit 31)
imem_ack  in  1  instruction word valid this cycle
dmem_ack  in  1  data access complete this cycle
imem_req  out  1  fetch request, held until ack
ir_load  out  1  latch instruction register (one-cycle pulse)
pc_load  out  1  update PC (one-cycle pulse)
pc_sel  out  2  0=PC+4, 1=label_addr, 2=PC+4+sext(comp_addr), 3=rs (reserved)
rf_we  out  1  register write enable (one-cycle pulse)
rf_wsel  out  2  0=ALU result, 1=dmem rdata, 2=PC+4 (link reg 31)
alu_src_imm  out  1  0=rt, 1=sign-extended imm_reg/imm_mem
alu_ctrl  out  4  ALU operation code
dmem_req  out  1  data access request, held until ack
dmem_we  out  1  1=store; valid while dmem_req
halted  out  1  level, high in HALT
illegal_op  out  1  one-cycle pulse on unknown opcode
bus_error  out  1  level, sticky until rst

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, HALT. On rst (sync): state=FETCH, timeout counter=0. All outputs 0 except imem_req, which is 1 from the first cycle after rst deasserts.
- FETCH: imem_req=1. On imem_ack: ir_load=1, go to DECODE. Count cycles without ack; at count==MEM_TIMEOUT: bus_error=1, go to HALT.
- DECODE: one cycle; all controls 0. Opcode classified via package constants:
  - OP_RALU=0: EXEC, alu_ctrl=func[3:0]; func[5:4]!=0 is illegal.
  - OP_ADDI=1 / OP_COMPI=10: EXEC.
  - OP_LD=2 / OP_ST=3: EXEC (address = rs + sext imm_mem).
  - OP_BR=4, OP_BZ=5, OP_BNZ=6, OP_BLTZ=7, OP_CALL=8: EXEC.
  - OP_HALT=9: go to HALT.
  - Any other opcode: illegal_op pulse, pc_load=1, pc_sel=0, go to FETCH (treated as NOP).
- EXEC:
  - ALU ops: go to WB.
  - LD/ST: alu_src_imm=1, alu_ctrl=ADD, go to MEM.
  - BR: pc_load=1, pc_sel=1, go to FETCH.
  - BZ/BNZ/BLTZ: if condition (rs_zero / !rs_zero / rs_neg) then pc_sel=2, else pc_sel=0; pc_load=1, go to FETCH.
  - CALL: rf_we=1, rf_wsel=2, pc_sel=1, pc_load=1, go to FETCH.
- MEM: dmem_req=1, dmem_we=(ST). Timeout as in FETCH. On dmem_ack: LD goes to WB; ST does pc_load=1, pc_sel=0 in the same cycle and goes to FETCH.
- WB: rf_we=1; rf_wsel=1 for LD, else 0. pc_load=1, pc_sel=0, go to FETCH.
- alu_ctrl and alu_src_imm hold their decoded values from EXEC through WB/MEM; they are 0 elsewhere.
- Timeout counter clears on every state entry. An ack arriving in the same cycle the counter hits MEM_TIMEOUT wins (no error).
- HALT is absorbing: only rst exits. rst mid-MEM drops dmem_req in the next cycle; no writeback occurs.
- CPI: ALU = 4 + fetch wait; LD = 5 + waits; ST/branch = 3 or 4 + waits.

Decomposition:
- Package minirisc_pkg: opcode constants, ALU codes (ADD=0, COMP=1, AND=2, XOR=3, SHLL=4, SHRL=5, SHLLV=6, SHRLV=7, SHRA=8, SHRAV=9), state enum, pc_sel/rf_wsel encodings.
- One sub-module, minirisc_mem_timer: timeout counter with clear/enable and an expired output, shared by FETCH and MEM.

Test Plan:
- rst then R-type add (opcode 0, func 0), imem_ack immediate -> ir_load at cycle 1, rf_we at cycle 4 with alu_ctrl=0, pc_sel=0, imem_req back high at cycle 5.
- LD with dmem_ack delayed 3 cycles -> dmem_req high for 4 cycles, dmem_we=0, then rf_we=1 with rf_wsel=1 for exactly 1 cycle.
- BZ with rs_zero=1 -> pc_sel=2; repeat with rs_zero=0 -> pc_sel=0; BLTZ with rs_neg=1 -> pc_sel=2; never rf_we in either case.
- CALL -> rf_we=1, rf_wsel=2, pc_sel=1, pc_load=1 in the same EXEC cycle.
- imem_ack never asserted -> bus_error=1 and halted=1 after 16 FETCH cycles; they stay set until rst, and imem_req=0 afterwards.
- opcode 63 -> illegal_op single pulse, pc_load with pc_sel=0, next fetch proceeds; opcode 9 -> halted=1 persists until rst.
